tl_ram_responder: RTL and testbench

- TileLink-UL manager (responder) that terminates the narrowed output of a fragmenter stage.
- Accepts single-beat Get, PutFullData and PutPartialData on channel A.
- Backed by a flop-based word array; returns AccessAck or AccessAckData on channel D through a 2-entry response queue.
- Sits as the slave endpoint behind the fragmenter in the test-harness memory-mapped region.

---
 rtl/tl_ram_pkg.sv | 18 +
 rtl/tl_resp_queue.sv | 44 ++++
 rtl/tl_ram_responder.sv | 96 +++++++++
 tb/tb_tl_ram_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tl_ram_pkg.sv
// tl_ram_pkg: TileLink-UL opcodes and the response-entry type shared by the RAM responder and its queue
package tl_ram_pkg;
   localparam logic [2:0] PUT_FULL    = 3'd0;
   localparam logic [2:0] PUT_PARTIAL = 3'd1;
   localparam logic [2:0] GET         = 3'd4;
   localparam logic [2:0] ACK         = 3'd0;
   localparam logic [2:0] ACK_DATA    = 3'd1;
   localparam int TL_SIZE_W   = 2;
   localparam int TL_SOURCE_W = 7;
   localparam int TL_DATA_W   = 64;
   typedef struct packed {
      logic [2:0]             opcode;
      logic [TL_SIZE_W-1:0]   size;
      logic [TL_SOURCE_W-1:0] source;
      logic                   denied;
      logic [TL_DATA_W-1:0]   data;
   } resp_t;
endpackage

// File: rtl/tl_resp_queue.sv
// tl_resp_queue: 2-entry FIFO of D-channel responses; ready depends only on the registered count
module tl_resp_queue
   import tl_ram_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst_n,
   input  logic  i_valid,
   output logic  o_ready,
   input  resp_t i_entry,
   output logic  o_valid,
   input  logic  i_ready,
   output resp_t o_entry
);
   logic [1:0] r_count;
   logic       r_wr;
   logic       r_rd;
   resp_t      r_mem [2];
   logic       w_push;
   logic       w_pop;

   assign o_ready = (r_count != 2'd2);
   assign o_valid = (r_count != 2'd0);
   assign o_entry = r_mem[r_rd];
   assign w_push  = i_valid & o_ready;
   assign w_pop   = o_valid & i_ready;

   // storage, 1-bit wrapping pointers and occupancy; reset flushes everything and zeroes the head
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_count  <= 2'd0;
         r_wr     <= 1'b0;
         r_rd     <= 1'b0;
         r_mem[0] <= '0;
         r_mem[1] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_entry;
            r_wr        <= ~r_wr;
         end
         if (w_pop)
            r_rd <= ~r_rd;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
endmodule

// File: rtl/tl_ram_responder.sv
// tl_ram_responder: TileLink-UL single-beat RAM manager; TL_RAM_RESPONDER_CORRUPT_DENY_EN makes corrupt Puts denied
module tl_ram_responder
   import tl_ram_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = TL_DATA_W,
   parameter int SOURCE_W    = TL_SOURCE_W,
   parameter int SIZE_W      = TL_SIZE_W,
   parameter int DEPTH_WORDS = 512
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  a_ready,
   input  logic                  a_valid,
   input  logic [2:0]            a_opcode,
   input  logic [2:0]            a_param,
   input  logic [SIZE_W-1:0]     a_size,
   input  logic [SOURCE_W-1:0]   a_source,
   input  logic [ADDR_W-1:0]     a_address,
   input  logic [DATA_W/8-1:0]   a_mask,
   input  logic [DATA_W-1:0]     a_data,
   input  logic                  a_corrupt,
   input  logic                  d_ready,
   output logic                  d_valid,
   output logic [2:0]            d_opcode,
   output logic [SIZE_W-1:0]     d_size,
   output logic [SOURCE_W-1:0]   d_source,
   output logic                  d_denied,
   output logic [DATA_W-1:0]     d_data
);
   localparam int LANES  = DATA_W / 8;
   localparam int LANE_W = $clog2(LANES);
   localparam int IDX_W  = ADDR_W - LANE_W;

   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
   logic [IDX_W-1:0]  w_idx;
   logic              w_in_range;
   logic              w_is_get;
   logic              w_is_put;
   logic              w_corrupt_deny;
   logic              w_denied;
   logic              w_fire;
   logic              w_write;
   resp_t             w_entry;
   resp_t             w_head;
   logic              w_unused;

`ifdef TL_RAM_RESPONDER_CORRUPT_DENY_EN
   assign w_corrupt_deny = a_corrupt;
`else
   assign w_corrupt_deny = 1'b0;
`endif

   assign w_idx      = a_address[ADDR_W-1:LANE_W];
   assign w_in_range = 32'(w_idx) < 32'(DEPTH_WORDS);
   assign w_is_get   = (a_opcode == GET);
   assign w_is_put   = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
   assign w_denied   = !w_in_range || !(w_is_get || w_is_put) || (w_is_put && w_corrupt_deny);
   assign w_write    = w_fire && w_is_put && !w_denied;
   assign w_unused   = ^{a_param, a_address[LANE_W-1:0], a_corrupt};

   // build the response for the request on A; reads see every write committed on earlier edges
   always_comb begin
      w_entry        = '0;
      w_entry.opcode = w_is_get ? ACK_DATA : ACK;
      w_entry.size   = a_size;
      w_entry.source = a_source;
      w_entry.denied = w_denied;
      w_entry.data   = (w_is_get && !w_denied) ? r_mem[w_idx] : '0;
   end

   // byte-lane write into the word array; contents survive reset
   always_ff @(posedge clock)
      if (w_write)
         for (int i = 0; i < LANES; i++)
            if (a_mask[i])
               r_mem[w_idx][i*8 +: 8] <= a_data[i*8 +: 8];

   tl_resp_queue u_queue (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_valid (a_valid),
      .o_ready (a_ready),
      .i_entry (w_entry),
      .o_valid (d_valid),
      .i_ready (d_ready),
      .o_entry (w_head)
   );

   assign w_fire   = a_valid & a_ready;
   assign d_opcode = w_head.opcode;
   assign d_size   = w_head.size;
   assign d_source = w_head.source;
   assign d_denied = w_head.denied;
   assign d_data   = w_head.data;
endmodule

// File: tb/tb_tl_ram_responder.sv
// tb_tl_ram_responder: randomized bench with a transaction-level memory/response model
module tb_tl_ram_responder;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        a_ready;
   logic        a_valid = 1'b0;
   logic [2:0]  a_opcode = '0;
   logic [2:0]  a_param = '0;
   logic [1:0]  a_size = '0;
   logic [6:0]  a_source = '0;
   logic [11:0] a_address = '0;
   logic [7:0]  a_mask = '0;
   logic [63:0] a_data = '0;
   logic        a_corrupt = 1'b0;
   logic        d_ready = 1'b0;
   logic        d_valid;
   logic [2:0]  d_opcode;
   logic [1:0]  d_size;
   logic [6:0]  d_source;
   logic        d_denied;
   logic [63:0] d_data;

`ifdef TL_RAM_RESPONDER_CORRUPT_DENY_EN
   localparam bit CDENY = 1'b1;
`else
   localparam bit CDENY = 1'b0;
`endif

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  size;
      logic [6:0]  src;
      logic        den;
      logic [63:0] data;
   } rsp_t;

   rsp_t        exp_q[$];
   logic [63:0] mem [512];
   int          n_chk = 0;
   int          n_fail = 0;
   bit          fired = 0;
   bit          rand_dr = 0;
   bit          stall = 0;
   logic [76:0] held = '0;
   logic [2:0]  ops [8] = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd2, 3'd3, 3'd5, 3'd7};

   always #5 clock = ~clock;

   tl_ram_responder dut (
      .clock(clock), .reset(reset), .a_ready(a_ready), .a_valid(a_valid),
      .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
      .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
      .d_ready(d_ready), .d_valid(d_valid), .d_opcode(d_opcode), .d_size(d_size),
      .d_source(d_source), .d_denied(d_denied), .d_data(d_data)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // expected response of the request currently on A, applying its effect to the model memory
   function automatic rsp_t model();
      rsp_t r;
      int   idx = int'(a_address[11:3]);
      r.size = a_size;
      r.src  = a_source;
      r.den  = 1'b0;
      r.data = '0;
      r.op   = 3'd0;
      if (a_opcode == 3'd4) begin
         r.op   = 3'd1;
         r.data = mem[idx];
      end else if (a_opcode <= 3'd1) begin
         if (CDENY && a_corrupt) r.den = 1'b1;
         else for (int i = 0; i < 8; i++) if (a_mask[i]) mem[idx][i*8 +: 8] = a_data[i*8 +: 8];
      end else r.den = 1'b1;
      return r;
   endfunction

   task automatic cycle();
      rsp_t r;
      if (rand_dr) d_ready = ($urandom_range(0, 3) != 0);
      check("a_ready", 128'(a_ready), 128'(exp_q.size() < 2));
      check("d_valid", 128'(d_valid), 128'(exp_q.size() > 0));
      if (stall) check("d_hold", 128'({d_opcode, d_size, d_source, d_denied, d_data}), 128'(held));
      stall = d_valid && !d_ready;
      held  = {d_opcode, d_size, d_source, d_denied, d_data};
      if (d_valid && d_ready && exp_q.size() > 0) begin
         r = exp_q.pop_front();
         check("d_opcode", 128'(d_opcode), 128'(r.op));
         check("d_size", 128'(d_size), 128'(r.size));
         check("d_source", 128'(d_source), 128'(r.src));
         check("d_denied", 128'(d_denied), 128'(r.den));
         check("d_data", 128'(d_data), 128'(r.data));
      end
      fired = a_valid && a_ready;
      if (fired) exp_q.push_back(model());
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic drive(input logic [2:0] op, input logic [11:0] addr, input logic [7:0] m,
                        input logic [63:0] dat, input logic c, input logic [6:0] src, input logic [1:0] sz);
      a_valid   = 1'b1;
      a_opcode  = op;
      a_address = addr;
      a_mask    = m;
      a_data    = dat;
      a_corrupt = c;
      a_source  = src;
      a_size    = sz;
      a_param   = 3'($urandom);
   endtask

   task automatic wait_fire(input string tag);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!fired && n < 64);
      if (!fired) check({tag, "_timeout"}, 128'(0), 128'(1));
      a_valid = 1'b0;
   endtask

   task automatic req(input logic [2:0] op, input logic [11:0] addr, input logic [7:0] m,
                      input logic [63:0] dat, input logic c, input logic [6:0] src, input logic [1:0] sz);
      drive(op, addr, m, dat, c, src, sz);
      wait_fire("req");
   endtask

   task automatic drain();
      int n = 0;
      a_valid = 1'b0;
      d_ready = 1'b1;
      while (exp_q.size() > 0 && n < 32) begin
         cycle();
         n++;
      end
      check("drain", 128'(exp_q.size()), 128'(0));
   endtask

   initial begin
      #12;
      check("rst_d_valid", 128'(d_valid), 128'(0));
      check("rst_d_fields", 128'({d_opcode, d_size, d_source, d_denied, d_data}), 128'(0));
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      d_ready = 1'b1;
      for (int i = 0; i < 512; i++)
         req(3'd0, 12'(i * 8), 8'hFF, {$urandom, $urandom}, 1'b0, 7'(i), 2'd3);
      req(3'd0, 12'h010, 8'hFF, 64'h1122334455667788, 1'b0, 7'd1, 2'd3);
      req(3'd4, 12'h010, 8'hFF, 64'h0, 1'b0, 7'd2, 2'd3);
      req(3'd1, 12'h010, 8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b0, 7'd3, 2'd2);
      req(3'd4, 12'h010, 8'hFF, 64'h0, 1'b0, 7'd4, 2'd3);
      drain();
      d_ready = 1'b0;
      req(3'd4, 12'h010, 8'hFF, 64'h0, 1'b0, 7'd10, 2'd3);
      req(3'd4, 12'h018, 8'hFF, 64'h0, 1'b0, 7'd11, 2'd3);
      drive(3'd4, 12'h020, 8'hFF, 64'h0, 1'b0, 7'd12, 2'd3);
      cycle();
      cycle();
      d_ready = 1'b1;
      wait_fire("third");
      drain();
      req(3'd2, 12'h010, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0, 7'd20, 2'd3);
      req(3'd4, 12'h010, 8'hFF, 64'h0, 1'b0, 7'd21, 2'd3);
      req(3'd0, 12'h018, 8'hFF, 64'h0123456789ABCDEF, 1'b1, 7'd22, 2'd3);
      req(3'd4, 12'h018, 8'hFF, 64'h0, 1'b0, 7'd23, 2'd3);
      drain();
      d_ready = 1'b0;
      req(3'd4, 12'h020, 8'hFF, 64'h0, 1'b0, 7'd30, 2'd3);
      req(3'd4, 12'h028, 8'hFF, 64'h0, 1'b0, 7'd31, 2'd3);
      cycle();
      #2 reset = 1'b0;
      #1;
      check("async_rst_d_valid", 128'(d_valid), 128'(0));
      check("async_rst_a_ready", 128'(a_ready), 128'(1));
      exp_q.delete();
      stall = 0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      d_ready = 1'b1;
      req(3'd4, 12'h010, 8'hFF, 64'h0, 1'b0, 7'd32, 2'd3);
      req(3'd4, 12'h018, 8'hFF, 64'h0, 1'b0, 7'd33, 2'd3);
      drain();
      rand_dr = 1'b1;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 3) == 0) cycle();
         req(ops[$urandom_range(0, 7)], 12'($urandom), 8'($urandom), {$urandom, $urandom},
             1'($urandom), 7'($urandom), 2'($urandom));
      end
      rand_dr = 1'b0;
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
